core_fetch_arbiter: RTL and testbench
=====================================

# core_fetch_arbiter

Shares the core's single memory port between the instruction prefetch path and the load/store unit. It grants one requester at a time and allows one outstanding transaction. It returns read data as single-cycle pulses (`insn_valid`/`insn_data` feeding the prefetch `fetched`/`fetch_data` inputs; `data_ready`/`data_rdata` to the LSU). On pipeline flush it drops any in-flight instruction fetch, so stale words never reach the prefetch buffer.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while `insn_req` is pending before instruction fetch is forced through (≥1).
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush, same signal as prefetch `flush`.
- `insn_req` in 1: instruction fetch request (prefetch `fetch`).
- `insn_addr` in `ptr`: word address of the fetch.
- `insn_valid` out 1: one-cycle pulse, fetched word valid.
- `insn_data` out `word`: fetched word.
- `data_req` in 1: LSU request.
- `data_we` in 1: 1 means write.
- `data_addr` in `ptr`: word address.
- `data_wdata` in `word`: write data.
- `data_be` in 4: byte enables.
- `data_ready` out 1: one-cycle pulse, LSU transaction done.
- `data_rdata` out `word`: load data.
- `mem_addr` out `ptr`: memory address.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_wdata` out `word`: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_waitrequest` in 1: memory not accepting the current command.
- `mem_readdatavalid` in 1: read data valid.
- `mem_rdata` in `word`: read data.

## Operation
- States: IDLE, INSN, DATA, DISCARD.
- In IDLE, arbitration runs each cycle:
  - `data_req` wins by default.
  - `insn_req` wins if `data_req` is low, or if the starve counter equals `STARVE_LIMIT`.
- The winner's address, wdata, be and we are latched at grant. Requesters need not hold them afterwards.
- Starve counter:
  - Increments (saturating at `STARVE_LIMIT`) on each data grant while `insn_req` is high.
  - Clears on an insn grant, or whenever `insn_req` is low in IDLE.
- INSN/DATA read:
  - `mem_read` is held until a cycle with `mem_waitrequest`=0. The strobe then drops.
  - The state waits for `mem_readdatavalid`.
  - Data is registered to `insn_data` or `data_rdata` and the matching valid/ready pulses. The state returns to IDLE.
- DATA write: `mem_write` is held until `mem_waitrequest`=0. `data_ready` pulses, then the state returns to IDLE.
- Flush with an insn transaction granted and not yet answered (INSN state):
  - If the command is still unaccepted, `mem_read` stays asserted until accepted. Memory commands are never withdrawn.
  - The state moves to DISCARD. In DISCARD, `mem_readdatavalid` is consumed without any `insn_valid`, then the state returns to IDLE.
- Flush in the same cycle as `mem_readdatavalid` in INSN: the word is dropped and `insn_valid` stays 0.
- Flush has no effect on DATA transactions. LSU ordering is owned downstream.
- Flush in IDLE suppresses an insn grant that cycle. A data grant is still allowed.
- `insn_req` dropping after grant does not cancel the transaction.

## Timing
- Reset values: all outputs 0, state IDLE, starve counter 0.
- Reset mid-transaction abandons it. The memory side shares `rst_n`.
- Grant in cycle N: `mem_*` is registered and asserted from cycle N+1.
- Read with zero wait states and `mem_readdatavalid` at N+2: `insn_valid` or `data_ready` at N+3.
- Write with zero wait states: `data_ready` at N+2.
- Earliest next grant is the cycle after the response pulse. This gives a maximum of one transaction per 3 cycles.
- `insn_valid` and `data_ready` are never asserted together.
- `mem_read` and `mem_write` are never asserted together.

## Configuration
- `CORE_FETCH_ARB_FAIRNESS_EN` defined: the starve counter and `STARVE_LIMIT` forcing are active as described above.
- Not defined: strict data priority. The counter logic is removed and `STARVE_LIMIT` is ignored. `insn_req` wins only when `data_req` is low.

## Test plan
- Idle start, `insn_req`=1, `insn_addr`=0x10, memory returns 0xDEADBEEF one cycle after accept, zero wait states -> `mem_read` at cycle 1, `insn_valid`=1 with `insn_data`=0xDEADBEEF at cycle 3, single pulse.
- `data_req` write, addr 0x20, be 4'b0011, 2 wait states -> `mem_write` held 3 cycles with stable addr, wdata and be; `data_ready` 1 cycle after acceptance; `insn_valid` never pulses.
- Both requests held continuously, fairness enabled, `STARVE_LIMIT`=4 -> grant order D,D,D,D,I repeating. With the macro undefined -> data only.
- Insn read accepted, `flush` pulsed before `mem_readdatavalid` -> state DISCARD, no `insn_valid`. The next `insn_req` issues a fresh `mem_read` after the discarded response.
- `flush` coincident with `mem_readdatavalid` in INSN -> no `insn_valid`, state IDLE next cycle.
- `rst_n` asserted during an outstanding data read -> all outputs 0 immediately (asynchronous), state IDLE after release, no late `data_ready`.

Source files
------------

// File: rtl/core_fetch_arbiter.sv
// Shares one memory port between instruction prefetch and the LSU, one transaction in flight.
// Define CORE_FETCH_ARB_FAIRNESS_EN to enable anti-starvation forcing of instruction fetches.
module core_fetch_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              insn_req,
    input  logic [ADDR_W-1:0] insn_addr,
    output logic              insn_valid,
    output logic [31:0]       insn_data,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_be,
    output logic              data_ready,
    output logic [31:0]       data_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        INSN,
        DATA,
        DISCARD
    } state_t;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              insn_valid_q, insn_valid_d;
    logic [31:0]       insn_data_q, insn_data_d;
    logic              data_ready_q, data_ready_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    logic idle_free;
    logic grant_insn;
    logic grant_data;
    logic cmd_accepted;
    logic read_done;
    logic starved;

    // A response pulse blocks arbitration for its cycle so the next grant comes strictly after it.
    assign idle_free    = (state_q == IDLE) && !insn_valid_q && !data_ready_q;
    assign grant_insn   = idle_free && insn_req && !flush && (!data_req || starved);
    assign grant_data   = idle_free && data_req && !grant_insn;
    assign cmd_accepted = !mem_waitrequest;
    assign read_done    = !mem_read_q && mem_readdatavalid;

`ifdef CORE_FETCH_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (grant_insn || (state_q == IDLE && !insn_req)) begin
            starve_d = '0;
        end else if (grant_data && insn_req && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        insn_valid_d = 1'b0;
        insn_data_d  = insn_data_q;
        data_ready_d = 1'b0;
        data_rdata_d = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_insn) begin
                    state_d    = INSN;
                    mem_addr_d = insn_addr;
                    mem_read_d = 1'b1;
                end else if (grant_data) begin
                    state_d     = DATA;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    mem_be_d    = data_be;
                    mem_read_d  = !data_we;
                    mem_write_d = data_we;
                end
            end

            // A flushed fetch still lets its command complete; only the returned word is dropped.
            INSN: begin
                if (mem_read_q && cmd_accepted) begin
                    mem_read_d = 1'b0;
                end
                if (read_done) begin
                    state_d = IDLE;
                    if (!flush) begin
                        insn_valid_d = 1'b1;
                        insn_data_d  = mem_rdata;
                    end
                end else if (flush) begin
                    state_d = DISCARD;
                end
            end

            // Writes leave on acceptance, so mem_write_q alone tells a pending write from a read.
            DATA: begin
                if (mem_write_q) begin
                    if (cmd_accepted) begin
                        mem_write_d  = 1'b0;
                        data_ready_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else begin
                    if (mem_read_q && cmd_accepted) begin
                        mem_read_d = 1'b0;
                    end
                    if (read_done) begin
                        data_ready_d = 1'b1;
                        data_rdata_d = mem_rdata;
                        state_d      = IDLE;
                    end
                end
            end

            DISCARD: begin
                if (mem_read_q && cmd_accepted) begin
                    mem_read_d = 1'b0;
                end
                if (read_done) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            insn_valid_q <= 1'b0;
            insn_data_q  <= '0;
            data_ready_q <= 1'b0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            insn_valid_q <= insn_valid_d;
            insn_data_q  <= insn_data_d;
            data_ready_q <= data_ready_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign insn_valid = insn_valid_q;
    assign insn_data  = insn_data_q;
    assign data_ready = data_ready_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_core_fetch_arbiter.sv
// Directed bench for core_fetch_arbiter: vector table plus hand-written flush/reset/fairness sequences.
module tb_core_fetch_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        insn_req;
    logic [31:0] insn_addr;
    logic        insn_valid;
    logic [31:0] insn_data;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    core_fetch_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .insn_req          (insn_req),
        .insn_addr         (insn_addr),
        .insn_valid        (insn_valid),
        .insn_data         (insn_data),
        .data_req          (data_req),
        .data_we           (data_we),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_be           (data_be),
        .data_ready        (data_ready),
        .data_rdata        (data_rdata),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_rdata         (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        insnReq;
        logic [31:0] insnAddr;
        logic        dataReq;
        logic        dataWe;
        logic [31:0] dataAddr;
        logic [31:0] dataWdata;
        logic [3:0]  dataBe;
        logic        flush;
        logic        waitReq;
        logic        rdv;
        logic [31:0] rdata;
        logic        expInsnValid;
        logic [31:0] expInsnData;
        logic        expDataReady;
        logic [31:0] expDataRdata;
        logic        expMemRead;
        logic        expMemWrite;
        logic [31:0] expMemAddr;
        logic [31:0] expMemWdata;
        logic [3:0]  expMemBe;
    } vec_t;

    function automatic vec_t mk(
        input logic iReq, input logic [31:0] iAddr,
        input logic dReq, input logic dWe, input logic [31:0] dAddr,
        input logic [31:0] dWdata, input logic [3:0] dBe,
        input logic fl, input logic wr, input logic rv, input logic [31:0] rd,
        input logic eIv, input logic [31:0] eId, input logic eDr, input logic [31:0] eDrd,
        input logic eMr, input logic eMw, input logic [31:0] eMa,
        input logic [31:0] eWd, input logic [3:0] eBe);
        vec_t v;
        v.insnReq = iReq;     v.insnAddr = iAddr;
        v.dataReq = dReq;     v.dataWe = dWe;     v.dataAddr = dAddr;
        v.dataWdata = dWdata; v.dataBe = dBe;
        v.flush = fl;         v.waitReq = wr;     v.rdv = rv;   v.rdata = rd;
        v.expInsnValid = eIv; v.expInsnData = eId;
        v.expDataReady = eDr; v.expDataRdata = eDrd;
        v.expMemRead = eMr;   v.expMemWrite = eMw; v.expMemAddr = eMa;
        v.expMemWdata = eWd;  v.expMemBe = eBe;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        flush = 0; insn_req = 0; insn_addr = 0;
        data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0; data_be = 0;
        mem_waitrequest = 0; mem_readdatavalid = 0; mem_rdata = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        insn_req = v.insnReq;   insn_addr = v.insnAddr;
        data_req = v.dataReq;   data_we = v.dataWe;   data_addr = v.dataAddr;
        data_wdata = v.dataWdata; data_be = v.dataBe;
        flush = v.flush;        mem_waitrequest = v.waitReq;
        mem_readdatavalid = v.rdv; mem_rdata = v.rdata;
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        checkBit($sformatf("vec%0d insn_valid", idx), insn_valid, v.expInsnValid);
        checkOutput($sformatf("vec%0d insn_data", idx), insn_data, v.expInsnData);
        checkBit($sformatf("vec%0d data_ready", idx), data_ready, v.expDataReady);
        checkOutput($sformatf("vec%0d data_rdata", idx), data_rdata, v.expDataRdata);
        checkBit($sformatf("vec%0d mem_read", idx), mem_read, v.expMemRead);
        checkBit($sformatf("vec%0d mem_write", idx), mem_write, v.expMemWrite);
        checkOutput($sformatf("vec%0d mem_addr", idx), mem_addr, v.expMemAddr);
        checkOutput($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.expMemWdata);
        checkOutput($sformatf("vec%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.expMemBe});
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, " insn_valid"}, insn_valid, 1'b0);
        checkOutput({tag, " insn_data"}, insn_data, 32'h0);
        checkBit({tag, " data_ready"}, data_ready, 1'b0);
        checkOutput({tag, " data_rdata"}, data_rdata, 32'h0);
        checkBit({tag, " mem_read"}, mem_read, 1'b0);
        checkBit({tag, " mem_write"}, mem_write, 1'b0);
        checkOutput({tag, " mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, " mem_be"}, {28'd0, mem_be}, 32'h0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[20];

    initial begin
        logic rdvNext;
        logic prevRead;
        logic prevWrite;
        logic gotInsn[10];
        logic expInsn[10];
        int   grants;

        vecs[0]  = mk(1, 32'h10, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 0, 32'h10, 0, 4'h0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF,
                      0, 0, 0, 0, 0, 0, 32'h10, 0, 4'h0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h10, 0, 4'h0);
        vecs[4]  = mk(0, 0, 1, 1, 32'h20, 32'hCAFE0001, 4'b0011, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h10, 0, 4'h0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h20, 32'hCAFE0001, 4'b0011);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h20, 32'hCAFE0001, 4'b0011);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h20, 32'hCAFE0001, 4'b0011);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 1, 0, 0, 0, 32'h20, 32'hCAFE0001, 4'b0011);
        vecs[9]  = mk(0, 0, 1, 0, 32'h30, 0, 4'hF, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h20, 32'hCAFE0001, 4'b0011);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 1, 0, 32'h30, 0, 4'hF);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 1, 0, 32'h30, 0, 4'hF);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h30, 0, 4'hF);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h12345678,
                      0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h30, 0, 4'hF);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 1, 32'h12345678, 0, 0, 32'h30, 0, 4'hF);
        vecs[15] = mk(1, 32'h99, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 32'h12345678, 0, 0, 32'h30, 0, 4'hF);
        vecs[16] = mk(1, 32'h99, 1, 1, 32'h50, 32'h11112222, 4'hF, 1, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 32'h12345678, 0, 0, 32'h30, 0, 4'hF);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 32'h12345678, 0, 1, 32'h50, 32'h11112222, 4'hF);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 1, 32'h12345678, 0, 0, 32'h50, 32'h11112222, 4'hF);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 32'h12345678, 0, 0, 32'h50, 32'h11112222, 4'hF);

        // Reset state
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            stepCycle();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(vecs[i], i);
        end

        // Both requesters held: record the order in which commands start
        for (int k = 0; k < 10; k++) begin
`ifdef CORE_FETCH_ARB_FAIRNESS_EN
            expInsn[k] = ((k % 5) == 4);
`else
            expInsn[k] = 1'b0;
`endif
            gotInsn[k] = 1'b0;
        end
        rdvNext = 0;
        prevRead = 0;
        prevWrite = 0;
        grants = 0;
        for (int c = 0; c < 80 && grants < 10; c++) begin
            stepCycle();
            clearInputs();
            insn_req = 1; insn_addr = 32'h100;
            data_req = 1; data_we = 1; data_addr = 32'h200; data_wdata = 32'h5; data_be = 4'hF;
            mem_readdatavalid = rdvNext; mem_rdata = 32'h77;
            @(negedge clk);
            checkBit("arb no dual response", insn_valid & data_ready, 1'b0);
            checkBit("arb no dual command", mem_read & mem_write, 1'b0);
            if ((mem_read && !prevRead) || (mem_write && !prevWrite)) begin
                gotInsn[grants] = mem_read;
                grants++;
            end
            rdvNext = mem_read;
            prevRead = mem_read;
            prevWrite = mem_write;
        end
        checkOutput("arb grant count", grants, 10);
        for (int k = 0; k < 10; k++) begin
            checkBit($sformatf("arb grant %0d is insn", k), gotInsn[k], expInsn[k]);
        end
        for (int c = 0; c < 8; c++) begin
            stepCycle();
            clearInputs();
            mem_readdatavalid = rdvNext; mem_rdata = 32'h77;
            @(negedge clk);
            rdvNext = mem_read;
        end

        // Flush after the read was accepted: response discarded, fresh fetch afterwards
        stepCycle(); clearInputs(); insn_req = 1; insn_addr = 32'h40;
        @(negedge clk); checkBit("fa idle mem_read", mem_read, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fa mem_read", mem_read, 1'b1);
        checkOutput("fa mem_addr", mem_addr, 32'h40);
        stepCycle(); clearInputs(); flush = 1;
        @(negedge clk); checkBit("fa accepted", mem_read, 1'b0);
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'hBAD0BAD0;
        insn_req = 1; insn_addr = 32'h44;
        @(negedge clk); checkBit("fa no insn_valid", insn_valid, 1'b0);
        stepCycle(); clearInputs(); insn_req = 1; insn_addr = 32'h44;
        @(negedge clk); checkBit("fa discard no insn_valid", insn_valid, 1'b0);
        checkBit("fa no grant in discard", mem_read, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fa fresh mem_read", mem_read, 1'b1);
        checkOutput("fa fresh mem_addr", mem_addr, 32'h44);
        checkBit("fa still no insn_valid", insn_valid, 1'b0);
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk); checkBit("fa fresh accepted", mem_read, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fa fresh insn_valid", insn_valid, 1'b1);
        checkOutput("fa fresh insn_data", insn_data, 32'hA5A5A5A5);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fa single pulse", insn_valid, 1'b0);

        // Flush while the read command is still stalled: strobe must stay up
        stepCycle(); clearInputs(); insn_req = 1; insn_addr = 32'h60;
        @(negedge clk);
        stepCycle(); clearInputs(); mem_waitrequest = 1; flush = 1;
        @(negedge clk); checkBit("fs mem_read", mem_read, 1'b1);
        checkOutput("fs mem_addr", mem_addr, 32'h60);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fs mem_read held", mem_read, 1'b1);
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'h0BADF00D;
        @(negedge clk); checkBit("fs accepted", mem_read, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fs no insn_valid", insn_valid, 1'b0);
        checkOutput("fs insn_data kept", insn_data, 32'hA5A5A5A5);

        // Flush coincident with the returning word
        stepCycle(); clearInputs(); insn_req = 1; insn_addr = 32'h70;
        @(negedge clk);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fc mem_read", mem_read, 1'b1);
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'hFEEDFACE; flush = 1;
        @(negedge clk);
        stepCycle(); clearInputs(); insn_req = 1; insn_addr = 32'h74;
        @(negedge clk); checkBit("fc no insn_valid", insn_valid, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fc idle regrant", mem_read, 1'b1);
        checkOutput("fc regrant addr", mem_addr, 32'h74);
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'h13579BDF;
        @(negedge clk);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("fc insn_valid", insn_valid, 1'b1);
        checkOutput("fc insn_data", insn_data, 32'h13579BDF);

        // Asynchronous reset during an outstanding data read
        stepCycle(); clearInputs(); data_req = 1; data_we = 0; data_addr = 32'h80; data_be = 4'hF;
        @(negedge clk);
        stepCycle(); clearInputs(); mem_waitrequest = 1;
        #1;
        checkBit("rst pre mem_read", mem_read, 1'b1);
        checkOutput("rst pre mem_addr", mem_addr, 32'h80);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst async");
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'hDDDDDDDD;
        stepCycle();
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle(); clearInputs(); insn_req = 1; insn_addr = 32'h90;
        @(negedge clk); checkBit("rst no late data_ready", data_ready, 1'b0);
        checkBit("rst idle mem_read", mem_read, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("rst idle grant", mem_read, 1'b1);
        checkOutput("rst grant addr", mem_addr, 32'h90);
        checkBit("rst data_ready low", data_ready, 1'b0);
        stepCycle(); clearInputs(); mem_readdatavalid = 1; mem_rdata = 32'h24682468;
        @(negedge clk); checkBit("rst read accepted", mem_read, 1'b0);
        stepCycle(); clearInputs();
        @(negedge clk); checkBit("rst insn_valid", insn_valid, 1'b1);
        checkOutput("rst insn_data", insn_data, 32'h24682468);
        checkBit("rst data_ready still low", data_ready, 1'b0);
        checkOutput("rst data_rdata", data_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
